input_shift_register: RTL

- PIO state-machine input shift register (ISR): the receive-direction counterpart of the MOV/OUT data-transform path.
- Accumulates bits from IN instructions and tracks the shift count.
- Performs explicit PUSH and autopush of the ISR into the RX FIFO through a valid/ready handshake, and stalls the state machine while a push is pending.
- Sits between the instruction execute stage and the RX FIFO write port.

---
 rtl/input_shift_register_pkg.sv | 30 +++
 rtl/input_shift_register_merge.sv | 33 +++
 rtl/input_shift_register.sv | 135 +++++++++++++
 3 files changed

// File: rtl/input_shift_register_pkg.sv
// Shared definitions for the PIO input shift register.
// Op codes, shift directions, FSM states and field decoders.
package input_shift_register_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_IN      = 2'b01,
    OP_PUSH    = 2'b10,
    OP_MOV_ISR = 2'b11
  } isr_op_e;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef enum logic {
    IDLE      = 1'b0,
    PUSH_WAIT = 1'b1
  } isr_state_e;

  // 5-bit count fields use 0 to mean 32
  function automatic logic [CNT_WIDTH-1:0] decode_n(
    input logic [4:0] v
  );
    return (v == 5'd0) ? 6'd32 : {1'b0, v};
  endfunction

endpackage

// File: rtl/input_shift_register_merge.sv
// Merges n new bits into a shift register word.
// Shared by the input and output shift paths.
module isr_shift_merge
  import input_shift_register_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_isr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CNT_WIDTH-1:0]  i_n,
  input  logic                  i_dir,
  output logic [DATA_WIDTH-1:0] o_isr_next
);

  logic [4:0]            w_sh;
  logic [CNT_WIDTH-1:0]  w_rsh;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_bits;

  always_comb begin
    w_sh   = i_n[4:0];
    w_rsh  = 6'd32 - i_n;
    w_mask = ~({DATA_WIDTH{1'b1}} << w_sh);
    w_bits = i_data & w_mask;
    // i_n is 1..32, so bit 5 alone flags a full-word load
    if (i_n[5]) begin
      o_isr_next = i_data;
    end else if (i_dir == SHIFT_RIGHT) begin
      o_isr_next = (w_bits << w_rsh) | (i_isr >> w_sh);
    end else begin
      o_isr_next = (i_isr << w_sh) | w_bits;
    end
  end

endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: IN accumulation, PUSH/autopush
// into the RX FIFO with a stall while the push is pending.
module input_shift_register
  import input_shift_register_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [4:0]            in_bit_count,
  input  logic                  in_shift_dir,
  input  logic                  in_autopush_en,
  input  logic [4:0]            in_push_thresh,
  input  logic                  in_push_iffull,
  input  logic                  in_push_block,
  input  logic                  in_push_ready,
  output logic                  out_push_valid,
  output logic [DATA_WIDTH-1:0] out_push_data,
  output logic [DATA_WIDTH-1:0] out_isr_data,
  output logic [CNT_WIDTH-1:0]  out_shift_count,
  output logic                  out_stall,
  output logic                  out_rx_drop
);

  isr_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_isr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_push_valid;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic                  r_rx_drop;

  isr_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] w_isr_nxt;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic [DATA_WIDTH-1:0] w_push_data_nxt;
  logic                  w_drop_nxt;

  isr_op_e               w_op;
  logic [CNT_WIDTH-1:0]  w_n;
  logic [CNT_WIDTH-1:0]  w_thresh;
  logic [CNT_WIDTH:0]    w_sum;
  logic [CNT_WIDTH-1:0]  w_cnt_sat;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_op     = isr_op_e'(in_op);
  assign w_n      = decode_n(in_bit_count);
  assign w_thresh = decode_n(in_push_thresh);
  assign w_sum    = {1'b0, r_count} + {1'b0, w_n};
  assign w_cnt_sat =
    (w_sum > 7'd32) ? 6'd32 : w_sum[CNT_WIDTH-1:0];

  isr_shift_merge u_merge (
    .i_isr      (r_isr),
    .i_data     (in_data),
    .i_n        (w_n),
    .i_dir      (in_shift_dir),
    .o_isr_next (w_merged)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_isr_nxt       = r_isr;
    w_count_nxt     = r_count;
    w_push_data_nxt = r_push_data;
    w_drop_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        unique case (w_op)
          OP_IN: begin
            // Autopush holds isr/count until the FIFO accepts
            if (in_autopush_en && (w_cnt_sat >= w_thresh)) begin
              w_push_data_nxt = w_merged;
              w_state_nxt     = PUSH_WAIT;
            end else begin
              w_isr_nxt   = w_merged;
              w_count_nxt = w_cnt_sat;
            end
          end
          OP_PUSH: begin
            if (in_push_iffull && (r_count < w_thresh)) begin
              w_state_nxt = IDLE;
            end else if (in_push_block || in_push_ready) begin
              w_push_data_nxt = r_isr;
              w_state_nxt     = PUSH_WAIT;
            end else begin
              w_isr_nxt   = '0;
              w_count_nxt = '0;
              w_drop_nxt  = 1'b1;
            end
          end
          OP_MOV_ISR: begin
            w_isr_nxt   = in_data;
            w_count_nxt = '0;
          end
          OP_NONE: begin
            w_state_nxt = IDLE;
          end
        endcase
      end
      PUSH_WAIT: begin
        if (r_push_valid && in_push_ready) begin
          w_isr_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_isr        <= '0;
      r_count      <= '0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_rx_drop    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_isr        <= w_isr_nxt;
      r_count      <= w_count_nxt;
      r_push_valid <= (w_state_nxt == PUSH_WAIT);
      r_push_data  <= w_push_data_nxt;
      r_rx_drop    <= w_drop_nxt;
    end
  end

  assign out_push_valid  = r_push_valid;
  assign out_push_data   = r_push_data;
  assign out_isr_data    = r_isr;
  assign out_shift_count = r_count;
  assign out_stall       = (r_state == PUSH_WAIT);
  assign out_rx_drop     = r_rx_drop;

endmodule
